// File: rtl/booth_mul4_pkg.sv
// Shared types and constants for the booth_mul4 radix-2 Booth multiplier.
package booth_mul4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned N      = 4;
  localparam int unsigned PROD_W = 8;
  localparam logic [1:0]  CNT_LAST = 2'(N - 1);

endpackage

// File: rtl/booth_mul4_if.sv
// Operand/result handshake bundle for booth_mul4.
interface booth_mul4_if;
  import booth_mul4_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        mcand;
  logic [3:0]        mplier;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] prod;

  modport master (
    output in_valid, mcand, mplier, out_ready,
    input  in_ready, out_valid, prod
  );

  modport slave (
    input  in_valid, mcand, mplier, out_ready,
    output in_ready, out_valid, prod
  );
endinterface

// File: rtl/booth_mul4_adds4.sv
// ADDS4: 4-bit add (m=0) / subtract (m=1) stage with signed overflow flag.
module booth_mul4_adds4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       m,
  output logic [3:0] s,
  output logic       v
);

  logic [3:0] b_eff;

  // Two's-complement add/subtract and overflow detection
  always_comb begin
    b_eff = b ^ {4{m}};
    s     = a + b_eff + {3'b000, m};
    v     = (a[3] == b_eff[3]) && (s[3] != a[3]);
  end

endmodule

// File: rtl/booth_mul4.sv
// Sequential radix-2 Booth multiplier, signed 4x4 -> 8 bits, valid/ready on both sides.
// Optional macro BOOTH_MUL4_ZERO_SKIP_EN: zero operands jump straight to DONE.
module booth_mul4
  import booth_mul4_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  booth_mul4_if.slave   bus
);

  state_t     state_r, state_s;
  logic [3:0] acc_r, acc_s;
  logic [3:0] q_r, q_s;
  logic       q1_r, q1_s;
  logic [3:0] mc_r, mc_s;
  logic [1:0] cnt_r, cnt_s;

  logic [3:0] sum_s;
  logic       ovf_s;
  logic       en_s;
  logic [3:0] acc_n_s;
  logic       sgn_s;

  booth_mul4_adds4 u_adds4 (
    .a (acc_r),
    .b (mc_r),
    .m (q_r[0]),
    .s (sum_s),
    .v (ovf_s)
  );

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= 4'h0;
      q_r     <= 4'h0;
      q1_r    <= 1'b0;
      mc_r    <= 4'h0;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      q_r     <= q_s;
      q1_r    <= q1_s;
      mc_r    <= mc_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic and one Booth step per CALC cycle
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    q_s     = q_r;
    q1_s    = q1_r;
    mc_s    = mc_r;
    cnt_s   = cnt_r;

    en_s    = q_r[0] ^ q1_r;
    acc_n_s = en_s ? sum_s : acc_r;
    // Overflow-corrected sign keeps MC=-8 subtraction exact
    sgn_s   = en_s ? (sum_s[3] ^ ovf_s) : acc_r[3];

    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          mc_s  = bus.mcand;
          q_s   = bus.mplier;
          acc_s = 4'h0;
          q1_s  = 1'b0;
          cnt_s = 2'd0;
`ifdef BOOTH_MUL4_ZERO_SKIP_EN
          if ((bus.mcand == 4'h0) || (bus.mplier == 4'h0)) begin
            q_s     = 4'h0;
            state_s = DONE;
          end else begin
            state_s = CALC;
          end
`else
          state_s = CALC;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        acc_s = {sgn_s, acc_n_s[3:1]};
        q_s   = {acc_n_s[0], q_r[3:1]};
        q1_s  = q_r[0];
        cnt_s = cnt_r + 2'd1;
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.prod      = {acc_r, q_r};

endmodule

// File: tb/tb_booth_mul4.sv
// Self-checking bench for booth_mul4: directed cases, reset abort, full 256-pair sweep.
module tb_booth_mul4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  booth_mul4_if bus ();

  booth_mul4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, wait for the result, optionally stall, then hand it off.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input int hold,
                       input bit rand_rdy, input string tag);
    int         p;
    logic [7:0] exp_p;
    int         exp_lat;
    int         lat;
    int         guard;
    bit         xfer;
    p       = $signed(a) * $signed(b);
    exp_p   = 8'(p);
    exp_lat = 4;
`ifdef BOOTH_MUL4_ZERO_SKIP_EN
    // DONE is entered on the accepting edge itself
    if ((a == 4'h0) || (b == 4'h0)) exp_lat = 0;
`endif
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.mcand    = a;
    bus.mplier   = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.mcand    = 4'(~a);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_prod"}, 32'(bus.prod), 32'(exp_p));
    for (int i = 0; i < hold; i++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.mplier    = 4'(i);
      step();
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_hold_prod"}, 32'(bus.prod), 32'(exp_p));
    end
    bus.in_valid = 1'b0;
    guard = 0;
    xfer  = 1'b0;
    while (!xfer && guard < 50) begin
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      xfer = bus.out_ready && bus.out_valid;
      if (!xfer) check({tag, "_wait_prod"}, 32'(bus.prod), 32'(exp_p));
      step();
      guard++;
    end
    check({tag, "_handoff"}, 32'(xfer), 32'd1);
    check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mcand     = 4'h0;
    bus.mplier    = 4'h0;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_prod", 32'(bus.prod), 32'h00);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    do_op(4'd3, 4'd5, 0, 1'b0, "mul_3x5");
    do_op(4'h8, 4'h8, 0, 1'b0, "mul_m8xm8");
    do_op(4'h8, 4'h7, 0, 1'b0, "mul_m8x7");
    do_op(4'h7, 4'hF, 6, 1'b0, "mul_7xm1_stall");
    do_op(4'h0, 4'hB, 0, 1'b0, "mul_0xm5");

    // Abort mid-CALC: reset sampled at the second Booth step
    bus.mcand    = 4'd5;
    bus.mplier   = 4'd6;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_prod", 32'(bus.prod), 32'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_no_result", 32'(bus.out_valid), 32'd0);
    end
    do_op(4'd2, 4'd3, 0, 1'b0, "mul_2x3");

    // Every signed pair, random idle gaps and random consumer readiness
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          step();
          check("sweep_gap_idle", 32'(bus.out_valid), 32'd0);
        end
        do_op(4'(a), 4'(b), 0, 1'b1, "sweep");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
